// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed-select or round-robin arbitration and a registered output.
// Optional packet lock (grant held until in_last) enabled by defining STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr #(
  parameter int WIDTH = 4,
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [N-1:0]       in_last,
  output logic               out_last,
`endif
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  input  logic               out_ready
);

  logic [N-1:0]     grant;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] gidx;
  logic             found;
  logic             free;
  logic             xfer;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             locked;
`endif

  assign free     = !out_valid || out_ready;
  assign in_ready = free ? grant : '0;
  assign xfer     = |(in_valid & in_ready);

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    if (mode) begin
      // Search starts one past the last transferred channel, wrapping modulo N.
      for (int unsigned k = 1; k <= N; k++) begin
        idx = SEL_W'((32'(ptr) + k) % N);
        if (!found && in_valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end else if (32'(sel) < N) begin
      grant[sel] = in_valid[sel];
    end
`ifdef STREAM_MUX_PKT_LOCK_EN
    // While a packet is open, ptr is the owning channel and overrides mode/sel.
    if (locked) begin
      grant      = '0;
      grant[ptr] = in_valid[ptr];
    end
`endif
  end

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) gidx = SEL_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SEL_W'(N - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[32'(gidx)*WIDTH +: WIDTH];
      out_chan  <= gidx;
      ptr       <= gidx;
`ifdef STREAM_MUX_PKT_LOCK_EN
      out_last  <= in_last[gidx];
      locked    <= !in_last[gidx];
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed table-driven bench for stream_mux_rr (N=4) plus a small N=3 instance for sel >= N and odd wrap.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_ready;
  logic [3:0]  in_last;
  logic        out_last;

  logic        mode3;
  logic [1:0]  sel3;
  logic [2:0]  v3;
  logic [11:0] d3;
  logic [2:0]  ir3;
  logic        ov3;
  logic [3:0]  od3;
  logic [1:0]  oc3;
  logic        or3;
  logic [2:0]  l3;
  logic        ol3;

  int ncomp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(4), .N(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_chan(out_chan), .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(4), .N(3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
    .in_valid(v3), .in_data(d3),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last(l3), .out_last(ol3),
`endif
    .in_ready(ir3), .out_valid(ov3), .out_data(od3),
    .out_chan(oc3), .out_ready(or3)
  );

`ifndef STREAM_MUX_PKT_LOCK_EN
  assign out_last = 1'b0;
  assign ol3      = 1'b0;
`endif

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ready;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_chan;
    logic [3:0] exp_data;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncomp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // ch0=A ch1=B ch2=C ch3=D
    vecs[0]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
    vecs[1]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
    vecs[2]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD};
    vecs[3]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
    vecs[4]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
    vecs[5]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
    vecs[6]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD};
    vecs[7]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
    vecs[8]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
    vecs[9]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD};
    vecs[10] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
    vecs[11] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD};
    vecs[12] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
    vecs[13] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 4'hB};
    vecs[14] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 4'hB};
    vecs[15] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 4'hB};
    vecs[16] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
    vecs[17] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd2, 4'hC};
    vecs[18] = '{1'b0, 2'd0, 4'hE, 1'b1, 4'b0000, 1'b0, 2'd2, 4'hC};

    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = 16'hDCBA;
    out_ready = 1'b0; in_last = '0;
    mode3 = 1'b0; sel3 = '0; v3 = '0; d3 = 12'h321; or3 = 1'b0; l3 = '0;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_chan", 32'(out_chan), 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      mode = vecs[i].mode; sel = vecs[i].sel;
      in_valid = vecs[i].valid; out_ready = vecs[i].ready;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d out_chan", i), 32'(out_chan), 32'(vecs[i].exp_chan));
      check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
    end

    // Asynchronous reset while a beat is held under back-pressure.
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
    @(posedge clk); #1;
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset out_valid", 32'(out_valid), 32'd0);
    check("async reset out_data", 32'(out_data), 32'd0);
    check("async reset out_chan", 32'(out_chan), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("post-reset in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    check("post-reset out_chan", 32'(out_chan), 32'd0);
    check("post-reset out_data", 32'(out_data), 32'hA);

`ifdef STREAM_MUX_PKT_LOCK_EN
    begin
      logic [3:0] exp_rdy [4];
      logic [1:0] exp_ch  [4];
      logic       exp_lst [4];
      exp_rdy = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
      exp_ch  = '{2'd0, 2'd0, 2'd0, 2'd1};
      exp_lst = '{1'b0, 1'b0, 1'b1, 1'b0};
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; mode = 1'b1; in_valid = 4'b0011; in_last = '0; out_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
        if (b == 2) in_last = 4'b0001;
        if (b == 3) begin in_valid = 4'b0010; in_last = '0; end
        #1;
        check($sformatf("lock b%0d in_ready", b), 32'(in_ready), 32'(exp_rdy[b]));
        @(posedge clk); #1;
        check($sformatf("lock b%0d out_chan", b), 32'(out_chan), 32'(exp_ch[b]));
        check($sformatf("lock b%0d out_last", b), 32'(out_last), 32'(exp_lst[b]));
      end
    end
`endif

    // N=3: sel beyond range grants nothing; round-robin wraps modulo 3.
    mode3 = 1'b0; sel3 = 2'd3; v3 = 3'b111; or3 = 1'b1;
    #1;
    check("n3 sel>=N in_ready", 32'(ir3), 32'd0);
    @(posedge clk); #1;
    check("n3 sel>=N out_valid", 32'(ov3), 32'd0);
    begin
      logic [1:0] exp3 [4];
      exp3 = '{2'd0, 2'd1, 2'd2, 2'd0};
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; mode3 = 1'b1;
      for (int b = 0; b < 4; b++) begin
        #1;
        check($sformatf("n3 rr%0d in_ready", b), 32'(ir3), 32'(3'b001 << exp3[b]));
        @(posedge clk); #1;
        check($sformatf("n3 rr%0d out_chan", b), 32'(oc3), 32'(exp3[b]));
        check($sformatf("n3 rr%0d out_data", b), 32'(od3), 32'(exp3[b]) + 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
